// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings and default latencies.
// Both the E-stage decoder and the MDU itself import this package.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic mdu_is_long(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers.
// A long op captures its operands at accept, holds busy for a fixed number
// of cycles via a down-counter, then writes HI/LO on the final busy edge.
// mthi/mtlo write in a single edge without raising busy.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE_N  = CNT_W'(1);

  // 64-bit product; signed operands are sign-extended so the low 64 bits
  // of an unsigned multiply equal the two's-complement product.
  function automatic logic [63:0] mul64(input logic is_signed,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ae;
    logic [63:0] be;
    ae = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    be = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ae * be;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes and
  // restores signs afterwards: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000 / -1 falls out as quotient 0x80000000,
  // remainder 0 with no special case. A zero divisor returns zero; the
  // caller never commits that result.
  function automatic logic [63:0] div64(input logic is_signed,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      return 64'd0;
    end
    ua    = (is_signed && a[31]) ? (~a + 32'd1) : a;
    ub    = (is_signed && b[31]) ? (~b + 32'd1) : b;
    q_mag = ua / ub;
    r_mag = ua % ub;
    q     = (is_signed && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    r     = (is_signed && a[31])           ? (~r_mag + 32'd1) : r_mag;
    return {r, q};
  endfunction

  mdu_op_e          op_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  mdu_op_e          op_q, op_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      rt_q, rt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      prod;
  logic [63:0]      dres;

  assign op_in = mdu_op_e'(mdu_op);

  // Results depend only on captured operands, never on live E-stage inputs.
  always_comb begin
    prod = mul64(op_q == MDU_MULT, rs_q, rt_q);
    dres = div64(op_q == MDU_DIV, rs_q, rt_q);
  end

  // Next-state: run down an active op, or accept a new one when idle.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    rs_d  = rs_q;
    rt_d  = rt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (busy_q) begin
      // start is ignored while busy; the hazard unit re-presents the op.
      cnt_d = cnt_q - ONE_N;
      if (cnt_q == ONE_N) begin
        unique case (op_q)
          MDU_MULT, MDU_MULTU: begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
          MDU_DIV, MDU_DIVU: begin
            // Divide by zero leaves HI/LO untouched.
            if (rt_q != 32'd0) begin
              hi_d = dres[63:32];
              lo_d = dres[31:0];
            end
          end
          default: ;
        endcase
        op_d = MDU_NONE;
      end
    end else if (start) begin
      unique case (op_in)
        MDU_MULT, MDU_MULTU: begin
          cnt_d = MULT_N;
          op_d  = op_in;
          rs_d  = rs_data;
          rt_d  = rt_data;
        end
        MDU_DIV, MDU_DIVU: begin
          cnt_d = DIV_N;
          op_d  = op_in;
          rs_d  = rs_data;
          rt_d  = rt_data;
        end
        MDU_MTHI: hi_d = rs_data;
        MDU_MTLO: lo_d = rs_data;
        default: ;
      endcase
    end
    busy_d = (cnt_d != '0);
  end

  // State registers; reset clears everything and aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= MDU_NONE;
      rs_q   <= '0;
      rt_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      op_q   <= op_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed literal cases plus random traffic
// checked every cycle against a cycle-index based behavioural model.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests = 0;
  int fails = 0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A long op accepted at edge k keeps the unit busy after edges k..k+N-1
  // and commits at edge k+N. Tracked purely by absolute edge numbers.
  longint      edge_n = 0;
  longint      done_edge = 0;
  bit          pend = 0;
  bit          m_ok = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  function automatic logic [63:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    t  = '0;
    case (op)
      1: t = sa * sb;
      2: t = ua * ub;
      3: begin q = sa / sb; r = sa % sb; t = {r[31:0], q[31:0]}; end
      4: begin q = longint'(ua / ub); r = longint'(ua % ub); t = {r[31:0], q[31:0]}; end
      default: t = '0;
    endcase
    return t;
  endfunction

  always @(posedge clk) begin
    logic [63:0] res;
    edge_n++;
    if (reset) begin
      m_hi = '0; m_lo = '0; done_edge = 0; pend = 0; m_ok = 1;
    end else if (edge_n == done_edge) begin
      if (pend) begin m_hi = p_hi; m_lo = p_lo; end
      pend = 0;
    end else if (start && (edge_n - 1 >= done_edge)) begin
      case (int'(mdu_op))
        1, 2: begin
          done_edge = edge_n + MC;
          res = ref_result(int'(mdu_op), rs_data, rt_data);
          {p_hi, p_lo} = res;
          pend = 1;
        end
        3, 4: begin
          done_edge = edge_n + DC;
          pend = (rt_data != 0);
          if (pend) begin
            res = ref_result(int'(mdu_op), rs_data, rt_data);
            {p_hi, p_lo} = res;
          end
        end
        5: m_hi = rs_data;
        6: m_lo = rs_data;
        default: ;
      endcase
    end
  end

  // Compare process: every cycle after the first reset.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_busy", {31'd0, busy}, {31'd0, (edge_n < done_edge)});
      chk("model_hi", HI, m_hi);
      chk("model_lo", LO, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    step();
    start = 1'b0; mdu_op = 3'd0; rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic run_busy(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      chk(name, {31'd0, busy}, 32'd1);
      step();
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; rs_data = '0; rt_data = '0;
    @(negedge clk);
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;
    step();

    // signed multiply
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    run_busy("mult_busy", MC);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // unsigned multiply, accepted back-to-back
    issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("multu_hold_hi", HI, 32'hFFFF_FFFF);
    run_busy("multu_busy", MC);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // signed divide
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    run_busy("div_busy", DC);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // divide by zero leaves HI/LO
    issue(3'd4, 32'd7, 32'd0);
    run_busy("divu0_busy", DC);
    chk("divu0_lo", LO, 32'hFFFF_FFFD);
    chk("divu0_hi", HI, 32'hFFFF_FFFF);

    // overflow corner
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("divov_busy", DC);
    chk("divov_lo", LO, 32'h8000_0000);
    chk("divov_hi", HI, 32'h0000_0000);

    // mthi then mtlo on consecutive edges
    start = 1'b1; mdu_op = 3'd5; rs_data = 32'h1234_5678;
    step();
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'h8000_0000);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    mdu_op = 3'd6; rs_data = 32'h9ABC_DEF0;
    step();
    chk("mtlo_lo", LO, 32'h9ABC_DEF0);
    chk("mtlo_hi", HI, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; mdu_op = 3'd0;

    // start during busy is ignored
    issue(3'd4, 32'd100, 32'd7);
    step();
    step();
    start = 1'b1; mdu_op = 3'd1; rs_data = 32'd1000; rt_data = 32'd1000;
    step();
    start = 1'b0; mdu_op = 3'd0;
    for (int i = 0; i < DC - 3; i++) step();
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk("ign_lo", LO, 32'd14);
    chk("ign_hi", HI, 32'd2);

    // reset during busy aborts
    issue(3'd1, 32'd3, 32'd4);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    for (int i = 0; i < MC; i++) step();
    chk("abort_hi_later", HI, 32'd0);
    chk("abort_lo_later", LO, 32'd0);

    // random traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      start   = $urandom_range(0, 1);
      mdu_op  = 3'($urandom_range(0, 7));
      rs_data = pick();
      rt_data = pick();
      step();
    end
    reset = 1'b0; start = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
